axi_mem_responder: RTL and testbench
====================================

AXI_MEM_RESPONDER -- requirements
Module: axi_mem_responder

Interface
REQ-001 The block SHALL provide parameter BYTES_PER_WORD, default 4, giving the data bus width in bytes; legal values are 4, 8 and 16.
REQ-002 The block SHALL provide parameter ADDRESS_WIDTH, default 32, giving the AXI address width.
REQ-003 The block SHALL provide parameter ID_WIDTH, default 6, giving the AXI ID width.
REQ-004 The block SHALL provide parameter MEM_WORDS, default 1024, giving the memory depth in words; it must be a power of 2.
REQ-005 The block SHALL have one clock and an asynchronous, active-low reset, with the ports listed below.
- CLK  in  1  clock; all state changes on the rising edge.
- RST_N  in  1  asynchronous reset, active low.
REQ-006 The block SHALL provide the write-address channel ports below.
- S_AXI_awaddr in ADDRESS_WIDTH.
- S_AXI_awlen in 8.
- S_AXI_awsize in 3.
- S_AXI_awburst in 2.
- S_AXI_awid in ID_WIDTH.
- S_AXI_awvalid in 1.
- S_AXI_awready out 1.
REQ-007 The block SHALL provide the write-data channel ports below.
- S_AXI_wdata in BYTES_PER_WORD*8.
- S_AXI_wstrb in BYTES_PER_WORD.
- S_AXI_wlast in 1.
- S_AXI_wvalid in 1.
- S_AXI_wready out 1.
REQ-008 The block SHALL provide the write-response channel ports below.
- S_AXI_bid out ID_WIDTH.
- S_AXI_bresp out 2.
- S_AXI_bvalid out 1.
- S_AXI_bready in 1.
REQ-009 The block SHALL provide the read-address channel ports below.
- S_AXI_araddr in ADDRESS_WIDTH.
- S_AXI_arlen in 8.
- S_AXI_arsize in 3.
- S_AXI_arburst in 2.
- S_AXI_arid in ID_WIDTH.
- S_AXI_arvalid in 1.
- S_AXI_arready out 1.
REQ-010 The block SHALL provide the read-data channel ports below.
- S_AXI_rdata out BYTES_PER_WORD*8.
- S_AXI_rresp out 2.
- S_AXI_rlast out 1.
- S_AXI_rid out ID_WIDTH.
- S_AXI_rvalid out 1.
- S_AXI_rready in 1.

Function
REQ-011 The block SHALL act as an AXI4 slave with an internal memory of MEM_WORDS x BYTES_PER_WORD bytes.
REQ-012 The block SHALL address memory by word index = addr >> log2(BYTES_PER_WORD).
- An address is in range when addr < MEM_WORDS*BYTES_PER_WORD.
REQ-013 The read and write paths SHALL be independent, and each SHALL have exactly one burst outstanding at a time.
REQ-014 The write FSM SHALL have the states W_IDLE, W_DATA and W_RESP.
- awready=1 only in W_IDLE.
- On the AW handshake the FSM SHALL latch addr, len, size, burst and id, clear the beat counter, and go to W_DATA.
REQ-015 In W_DATA, wready SHALL be 1.
- Each W handshake SHALL write only the strobed bytes of the current word.
- An out-of-range beat SHALL write nothing.
REQ-016 The next beat address SHALL be computed as follows.
- INCR (burst 2'b01) and WRAP (2'b10): addr + 2^size.
- FIXED (2'b00): unchanged.
- Addition is ADDRESS_WIDTH-bit modular, with no 4KB boundary check.
REQ-017 When the beat counter reaches len, the FSM SHALL go to W_RESP.
- Beat count is governed by awlen only.
REQ-018 In W_RESP, bvalid SHALL be 1 with bid equal to the latched id.
- bvalid SHALL hold until bready=1, then the FSM returns to W_IDLE.
REQ-019 bresp SHALL be chosen in this priority order.
- DECERR (2'b11) if any beat was out of range.
- Otherwise SLVERR (2'b10) if wlast was mismatched on any beat (asserted early or missing on the final beat).
- Otherwise OKAY (2'b00).
REQ-020 The read FSM SHALL have the states R_IDLE, R_FETCH and R_DATA.
- arready=1 only in R_IDLE.
- On the AR handshake the FSM SHALL latch the request and go to R_FETCH.
REQ-021 R_FETCH SHALL last one cycle, registering the memory word into rdata, and then move to R_DATA.
REQ-022 In R_DATA, the read outputs SHALL be driven as follows.
- rvalid=1, rid = latched id, and rlast=1 on beat len.
- rresp=DECERR with rdata=0 for an out-of-range beat, otherwise OKAY.
- rdata, rresp and rlast SHALL be stable while rvalid=1 and rready=0.
REQ-023 On the R handshake the FSM SHALL go to R_IDLE if this was the last beat, otherwise advance the address per REQ-016 and go to R_FETCH.
REQ-024 Read latency SHALL be as follows.
- An AR handshake at cycle T gives the first rvalid at T+2.
- Peak read throughput is 1 beat per 2 cycles.
- Peak write throughput is 1 beat per cycle.
REQ-025 A same-word read fetch and write in the same cycle SHALL return the old data (read-before-write).

Reset
REQ-026 While RST_N=0, the outputs SHALL be held as follows.
- awready=0, wready=0, bvalid=0, arready=0, rvalid=0, rlast=0.
- bresp=0, rresp=0, bid=0, rid=0, rdata=0.
- Both FSMs in their idle state, with counters and error flags cleared.
REQ-027 Memory contents SHALL NOT be reset.
REQ-028 A reset asserted mid-burst SHALL abandon the burst without producing a response.
- After release, awready and arready SHALL be 1 on the first clock edge.

Verification
REQ-029 INCR write, then read back:
- Stimulus: AW addr=0x10, len=3, size=2, id=5; wdata 0x11111111..0x44444444 with full strobes. Then AR with the same parameters.
- Required: bresp=OKAY, bid=5; four R beats return the same data with rlast on beat 3 and rid=5.
REQ-030 Partial strobe:
- Stimulus: write 0xAABBCCDD at 0x0 with wstrb=4'b0101 over existing 0x00000000, then read.
- Required: read returns 0x00BB00DD.
REQ-031 FIXED burst:
- Stimulus: write len=2 at 0x8 with data 1, 2, 3.
- Required: a read of 0x8 returns 3.
REQ-032 Out of range:
- Stimulus: AR addr=MEM_WORDS*4, len=0.
- Required: rresp=DECERR, rdata=0.
- Stimulus: AW at the same address.
- Required: bresp=DECERR and memory unchanged.
REQ-033 Handshake stalls:
- Stimulus: wlast on beat 0 of a len=1 burst.
- Required: bresp=SLVERR.
- Stimulus: rready held at 0 for 5 cycles.
- Required: rvalid, rdata and rlast stay stable.
- Stimulus: bready held at 0.
- Required: awready stays 0.
REQ-034 Reset mid-burst:
- Stimulus: assert RST_N=0 after 1 of 4 write beats.
- Required: bvalid is never asserted, and awready=1 after release.

Source files
------------

// File: rtl/axi_mem_responder.sv
// AXI4 slave backed by an internal word-addressed memory.
// Independent read and write FSMs, each with exactly one burst outstanding.
module axi_mem_responder #(
  parameter int unsigned BYTES_PER_WORD = 4,
  parameter int unsigned ADDRESS_WIDTH  = 32,
  parameter int unsigned ID_WIDTH       = 6,
  parameter int unsigned MEM_WORDS      = 1024
) (
  input  logic                        CLK,
  input  logic                        RST_N,
  input  logic [ADDRESS_WIDTH-1:0]    S_AXI_awaddr,
  input  logic [7:0]                  S_AXI_awlen,
  input  logic [2:0]                  S_AXI_awsize,
  input  logic [1:0]                  S_AXI_awburst,
  input  logic [ID_WIDTH-1:0]         S_AXI_awid,
  input  logic                        S_AXI_awvalid,
  output logic                        S_AXI_awready,
  input  logic [BYTES_PER_WORD*8-1:0] S_AXI_wdata,
  input  logic [BYTES_PER_WORD-1:0]   S_AXI_wstrb,
  input  logic                        S_AXI_wlast,
  input  logic                        S_AXI_wvalid,
  output logic                        S_AXI_wready,
  output logic [ID_WIDTH-1:0]         S_AXI_bid,
  output logic [1:0]                  S_AXI_bresp,
  output logic                        S_AXI_bvalid,
  input  logic                        S_AXI_bready,
  input  logic [ADDRESS_WIDTH-1:0]    S_AXI_araddr,
  input  logic [7:0]                  S_AXI_arlen,
  input  logic [2:0]                  S_AXI_arsize,
  input  logic [1:0]                  S_AXI_arburst,
  input  logic [ID_WIDTH-1:0]         S_AXI_arid,
  input  logic                        S_AXI_arvalid,
  output logic                        S_AXI_arready,
  output logic [BYTES_PER_WORD*8-1:0] S_AXI_rdata,
  output logic [1:0]                  S_AXI_rresp,
  output logic                        S_AXI_rlast,
  output logic [ID_WIDTH-1:0]         S_AXI_rid,
  output logic                        S_AXI_rvalid,
  input  logic                        S_AXI_rready
);

  localparam int unsigned DW   = BYTES_PER_WORD * 8;
  localparam int unsigned OFFS = $clog2(BYTES_PER_WORD);
  localparam int unsigned IDXW = $clog2(MEM_WORDS);
  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlvErr = 2'b10;
  localparam logic [1:0] RespDecErr = 2'b11;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} r_state_e;

  logic [DW-1:0] mem [MEM_WORDS];

  function automatic logic in_range(input logic [ADDRESS_WIDTH-1:0] a);
    return a[ADDRESS_WIDTH-1:OFFS+IDXW] == '0;
  endfunction

  function automatic logic [IDXW-1:0] word_idx(input logic [ADDRESS_WIDTH-1:0] a);
    return a[OFFS+IDXW-1:OFFS];
  endfunction

  // FIXED holds the address; every other burst type steps by the beat size.
  function automatic logic [ADDRESS_WIDTH-1:0] next_addr(input logic [ADDRESS_WIDTH-1:0] a,
                                                         input logic [2:0] size,
                                                         input logic [1:0] burst);
    if (burst == 2'b00) return a;
    return a + (ADDRESS_WIDTH'(1) << size);
  endfunction

  // Held low through reset so both ready outputs rise on the first edge after release.
  logic live_q;

  w_state_e                 w_state_q, w_state_d;
  logic [ADDRESS_WIDTH-1:0] aw_addr_q, aw_addr_d;
  logic [7:0]               aw_len_q, aw_len_d, w_cnt_q, w_cnt_d;
  logic [2:0]               aw_size_q, aw_size_d;
  logic [1:0]               aw_burst_q, aw_burst_d;
  logic [ID_WIDTH-1:0]      aw_id_q, aw_id_d;
  logic                     w_dec_q, w_dec_d, w_slv_q, w_slv_d;
  logic                     mem_we;

  r_state_e                 r_state_q, r_state_d;
  logic [ADDRESS_WIDTH-1:0] ar_addr_q, ar_addr_d;
  logic [7:0]               ar_len_q, ar_len_d, r_cnt_q, r_cnt_d;
  logic [2:0]               ar_size_q, ar_size_d;
  logic [1:0]               ar_burst_q, ar_burst_d;
  logic [ID_WIDTH-1:0]      ar_id_q, ar_id_d;
  logic [DW-1:0]            rdata_q, rdata_d;
  logic [1:0]               rresp_q, rresp_d;
  logic                     rlast_q, rlast_d;

  always_comb begin
    w_state_d  = w_state_q;
    aw_addr_d  = aw_addr_q;
    aw_len_d   = aw_len_q;
    aw_size_d  = aw_size_q;
    aw_burst_d = aw_burst_q;
    aw_id_d    = aw_id_q;
    w_cnt_d    = w_cnt_q;
    w_dec_d    = w_dec_q;
    w_slv_d    = w_slv_q;
    mem_we     = 1'b0;
    case (w_state_q)
      W_IDLE: if (S_AXI_awvalid && live_q) begin
        aw_addr_d  = S_AXI_awaddr;
        aw_len_d   = S_AXI_awlen;
        aw_size_d  = S_AXI_awsize;
        aw_burst_d = S_AXI_awburst;
        aw_id_d    = S_AXI_awid;
        w_cnt_d    = '0;
        w_dec_d    = 1'b0;
        w_slv_d    = 1'b0;
        w_state_d  = W_DATA;
      end
      W_DATA: if (S_AXI_wvalid) begin
        mem_we = in_range(aw_addr_q);
        if (!in_range(aw_addr_q)) w_dec_d = 1'b1;
        if (S_AXI_wlast != (w_cnt_q == aw_len_q)) w_slv_d = 1'b1;
        if (w_cnt_q == aw_len_q) begin
          w_state_d = W_RESP;
        end else begin
          w_cnt_d   = w_cnt_q + 8'd1;
          aw_addr_d = next_addr(aw_addr_q, aw_size_q, aw_burst_q);
        end
      end
      W_RESP: if (S_AXI_bready) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    r_state_d  = r_state_q;
    ar_addr_d  = ar_addr_q;
    ar_len_d   = ar_len_q;
    ar_size_d  = ar_size_q;
    ar_burst_d = ar_burst_q;
    ar_id_d    = ar_id_q;
    r_cnt_d    = r_cnt_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;
    rlast_d    = rlast_q;
    case (r_state_q)
      R_IDLE: if (S_AXI_arvalid && live_q) begin
        ar_addr_d  = S_AXI_araddr;
        ar_len_d   = S_AXI_arlen;
        ar_size_d  = S_AXI_arsize;
        ar_burst_d = S_AXI_arburst;
        ar_id_d    = S_AXI_arid;
        r_cnt_d    = '0;
        r_state_d  = R_FETCH;
      end
      R_FETCH: begin
        rdata_d   = in_range(ar_addr_q) ? mem[word_idx(ar_addr_q)] : '0;
        rresp_d   = in_range(ar_addr_q) ? RespOkay : RespDecErr;
        rlast_d   = (r_cnt_q == ar_len_q);
        r_state_d = R_DATA;
      end
      R_DATA: if (S_AXI_rready) begin
        if (rlast_q) begin
          r_state_d = R_IDLE;
        end else begin
          r_cnt_d   = r_cnt_q + 8'd1;
          ar_addr_d = next_addr(ar_addr_q, ar_size_q, ar_burst_q);
          r_state_d = R_FETCH;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      live_q     <= 1'b0;
      w_state_q  <= W_IDLE;
      aw_addr_q  <= '0;
      aw_len_q   <= '0;
      aw_size_q  <= '0;
      aw_burst_q <= '0;
      aw_id_q    <= '0;
      w_cnt_q    <= '0;
      w_dec_q    <= 1'b0;
      w_slv_q    <= 1'b0;
      r_state_q  <= R_IDLE;
      ar_addr_q  <= '0;
      ar_len_q   <= '0;
      ar_size_q  <= '0;
      ar_burst_q <= '0;
      ar_id_q    <= '0;
      r_cnt_q    <= '0;
      rdata_q    <= '0;
      rresp_q    <= '0;
      rlast_q    <= 1'b0;
    end else begin
      live_q     <= 1'b1;
      w_state_q  <= w_state_d;
      aw_addr_q  <= aw_addr_d;
      aw_len_q   <= aw_len_d;
      aw_size_q  <= aw_size_d;
      aw_burst_q <= aw_burst_d;
      aw_id_q    <= aw_id_d;
      w_cnt_q    <= w_cnt_d;
      w_dec_q    <= w_dec_d;
      w_slv_q    <= w_slv_d;
      r_state_q  <= r_state_d;
      ar_addr_q  <= ar_addr_d;
      ar_len_q   <= ar_len_d;
      ar_size_q  <= ar_size_d;
      ar_burst_q <= ar_burst_d;
      ar_id_q    <= ar_id_d;
      r_cnt_q    <= r_cnt_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
      rlast_q    <= rlast_d;
    end
  end

  // No reset on the array; a same-cycle fetch sees the pre-write word.
  always_ff @(posedge CLK) begin
    if (mem_we) begin
      for (int b = 0; b < int'(BYTES_PER_WORD); b++) begin
        if (S_AXI_wstrb[b]) mem[word_idx(aw_addr_q)][8*b +: 8] <= S_AXI_wdata[8*b +: 8];
      end
    end
  end

  assign S_AXI_awready = (w_state_q == W_IDLE) && live_q;
  assign S_AXI_wready  = (w_state_q == W_DATA);
  assign S_AXI_bvalid  = (w_state_q == W_RESP);
  assign S_AXI_bid     = aw_id_q;
  assign S_AXI_bresp   = (w_state_q != W_RESP) ? RespOkay :
                         w_dec_q ? RespDecErr : w_slv_q ? RespSlvErr : RespOkay;
  assign S_AXI_arready = (r_state_q == R_IDLE) && live_q;
  assign S_AXI_rvalid  = (r_state_q == R_DATA);
  assign S_AXI_rid     = ar_id_q;
  assign S_AXI_rdata   = rdata_q;
  assign S_AXI_rresp   = rresp_q;
  assign S_AXI_rlast   = rlast_q;

endmodule

// File: tb/tb_axi_mem_responder.sv
// Directed and randomized AXI bursts checked against a byte-level memory model.
module tb_axi_mem_responder;
  localparam int MW = 1024;
  localparam logic [31:0] MEM_BYTES = 32'(MW * 4);

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic [31:0] awaddr = '0, araddr = '0;
  logic [7:0]  awlen = '0, arlen = '0;
  logic [2:0]  awsize = '0, arsize = '0;
  logic [1:0]  awburst = '0, arburst = '0;
  logic [5:0]  awid = '0, arid = '0;
  logic        awvalid = 1'b0, arvalid = 1'b0, wvalid = 1'b0, wlast = 1'b0;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        bready = 1'b0, rready = 1'b0;
  logic        awready, wready, bvalid, arready, rvalid, rlast;
  logic [5:0]  bid, rid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;

  axi_mem_responder dut (
    .CLK(CLK), .RST_N(RST_N),
    .S_AXI_awaddr(awaddr), .S_AXI_awlen(awlen), .S_AXI_awsize(awsize),
    .S_AXI_awburst(awburst), .S_AXI_awid(awid), .S_AXI_awvalid(awvalid),
    .S_AXI_awready(awready),
    .S_AXI_wdata(wdata), .S_AXI_wstrb(wstrb), .S_AXI_wlast(wlast),
    .S_AXI_wvalid(wvalid), .S_AXI_wready(wready),
    .S_AXI_bid(bid), .S_AXI_bresp(bresp), .S_AXI_bvalid(bvalid), .S_AXI_bready(bready),
    .S_AXI_araddr(araddr), .S_AXI_arlen(arlen), .S_AXI_arsize(arsize),
    .S_AXI_arburst(arburst), .S_AXI_arid(arid), .S_AXI_arvalid(arvalid),
    .S_AXI_arready(arready),
    .S_AXI_rdata(rdata), .S_AXI_rresp(rresp), .S_AXI_rlast(rlast), .S_AXI_rid(rid),
    .S_AXI_rvalid(rvalid), .S_AXI_rready(rready)
  );

  always #5 CLK = ~CLK;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] model [MW];
  logic [31:0] wd [256];
  logic [3:0]  ws [256];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic sig(input int which);
    case (which)
      0: return awready;
      1: return wready;
      2: return bvalid;
      3: return arready;
      4: return rvalid;
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_for(input int which, input string tag);
    int n = 0;
    while (!sig(which) && n < 200) begin
      @(negedge CLK);
      n++;
    end
    chk(tag, 64'(sig(which)), 64'd1);
  endtask

  function automatic logic [31:0] beat_addr(input logic [31:0] a, input int i,
                                            input int size, input int burst);
    return (burst == 0) ? a : a + 32'(i * (1 << size));
  endfunction

  task automatic check_reset_outputs(input string tag);
    chk(tag, {awready, wready, bvalid, arready, rvalid, rlast, bresp, rresp, bid, rid, rdata},
        64'd0);
  endtask

  // Drives one write burst (wd/ws hold beat data) and checks the B response.
  task automatic do_write(input logic [31:0] addr, input int len, input int size,
                          input int burst, input logic [5:0] id, input int bad_last,
                          input int bstall);
    logic dec = 1'b0, slv = 1'b0, last;
    logic [31:0] a;
    logic [1:0] exp_resp;
    for (int i = 0; i <= len; i++) begin
      a = beat_addr(addr, i, size, burst);
      last = (i == len) ^ (i == bad_last);
      if (last != (i == len)) slv = 1'b1;
      if (a >= MEM_BYTES) dec = 1'b1;
      else for (int b = 0; b < 4; b++) if (ws[i][b]) model[a >> 2][8*b +: 8] = wd[i][8*b +: 8];
    end
    exp_resp = dec ? 2'b11 : slv ? 2'b10 : 2'b00;
    @(negedge CLK);
    awaddr = addr; awlen = 8'(len); awsize = 3'(size); awburst = 2'(burst); awid = id;
    awvalid = 1'b1;
    wait_for(0, "awready");
    @(negedge CLK);
    awvalid = 1'b0;
    for (int i = 0; i <= len; i++) begin
      if ($urandom_range(3) == 0) @(negedge CLK);
      wdata = wd[i]; wstrb = ws[i]; wlast = (i == len) ^ (i == bad_last); wvalid = 1'b1;
      wait_for(1, "wready");
      @(negedge CLK);
      wvalid = 1'b0;
    end
    wait_for(2, "bvalid");
    for (int k = 0; k < bstall; k++) begin
      chk("awready_in_b_stall", 64'(awready), 64'd0);
      chk("bvalid_hold", 64'(bvalid), 64'd1);
      @(negedge CLK);
    end
    chk("bid", 64'(bid), 64'(id));
    chk("bresp", 64'(bresp), 64'(exp_resp));
    bready = 1'b1;
    @(negedge CLK);
    bready = 1'b0;
    chk("bvalid_drop", 64'(bvalid), 64'd0);
  endtask

  // Drives one read burst and checks every R beat against the model.
  task automatic do_read(input logic [31:0] addr, input int len, input int size,
                         input int burst, input logic [5:0] id, input int stall_beat);
    logic [31:0] a, exp_d;
    logic [1:0]  exp_r;
    @(negedge CLK);
    araddr = addr; arlen = 8'(len); arsize = 3'(size); arburst = 2'(burst); arid = id;
    arvalid = 1'b1;
    wait_for(3, "arready");
    @(negedge CLK);
    arvalid = 1'b0;
    chk("rvalid_during_fetch", 64'(rvalid), 64'd0);
    @(negedge CLK);
    chk("rvalid_latency", 64'(rvalid), 64'd1);
    for (int i = 0; i <= len; i++) begin
      if (i > 0) chk("rvalid_refetch", 64'(rvalid), 64'd0);
      wait_for(4, "rvalid");
      a = beat_addr(addr, i, size, burst);
      exp_d = (a < MEM_BYTES) ? model[a >> 2] : 32'd0;
      exp_r = (a < MEM_BYTES) ? 2'b00 : 2'b11;
      for (int k = 0; k <= ((i == stall_beat) ? 5 : 0); k++) begin
        if (k > 0) @(negedge CLK);
        chk("rvalid_hold", 64'(rvalid), 64'd1);
        chk("rdata", 64'(rdata), 64'(exp_d));
        chk("rresp", 64'(rresp), 64'(exp_r));
        chk("rlast", 64'(rlast), 64'(i == len));
      end
      chk("rid", 64'(rid), 64'(id));
      rready = 1'b1;
      @(negedge CLK);
      rready = 1'b0;
    end
    chk("rvalid_end", 64'(rvalid), 64'd0);
  endtask

  initial begin
    int len, size, burst, bad;
    logic [31:0] addr;
    logic [5:0]  id;
    for (int i = 0; i < MW; i++) model[i] = '0;
    repeat (3) @(negedge CLK);
    check_reset_outputs("reset_outputs");
    RST_N = 1'b1;
    @(negedge CLK);
    chk("awready_after_reset", 64'(awready), 64'd1);
    chk("arready_after_reset", 64'(arready), 64'd1);

    // Known contents for the low region and the top of memory.
    for (int i = 0; i < 256; i++) begin wd[i] = '0; ws[i] = 4'hF; end
    do_write(32'h0, 127, 2, 1, 6'd1, -1, 0);
    do_write(MEM_BYTES - 32, 7, 2, 1, 6'd2, -1, 0);

    for (int i = 0; i < 4; i++) wd[i] = 32'h11111111 * 32'(i + 1);
    do_write(32'h10, 3, 2, 1, 6'd5, -1, 2);
    do_read(32'h10, 3, 2, 1, 6'd5, 2);

    wd[0] = 32'hAABBCCDD; ws[0] = 4'b0101;
    do_write(32'h0, 0, 2, 1, 6'd3, -1, 0);
    do_read(32'h0, 0, 2, 1, 6'd3, -1);
    chk("partial_strobe_model", 64'(model[0]), 64'h00BB00DD);

    for (int i = 0; i < 3; i++) begin wd[i] = 32'(i + 1); ws[i] = 4'hF; end
    do_write(32'h8, 2, 2, 0, 6'd7, -1, 0);
    do_read(32'h8, 0, 2, 1, 6'd7, -1);

    do_read(MEM_BYTES, 0, 2, 1, 6'd9, 3);
    wd[0] = 32'hDEADBEEF;
    do_write(MEM_BYTES, 0, 2, 1, 6'd9, -1, 0);
    do_read(32'h0, 0, 2, 1, 6'd9, -1);

    wd[0] = 32'h12345678; wd[1] = 32'h9ABCDEF0;
    do_write(32'h20, 1, 2, 1, 6'd11, 0, 3);
    do_write(32'h28, 1, 2, 1, 6'd12, 2, 0);
    do_read(32'h20, 1, 2, 1, 6'd11, -1);

    for (int t = 0; t < 25; t++) begin
      len   = $urandom_range(7);
      size  = $urandom_range(2);
      burst = $urandom_range(2);
      id    = 6'($urandom);
      addr  = ($urandom_range(4) == 0) ? MEM_BYTES - 32'($urandom_range(40)) :
                                         32'($urandom_range(255));
      bad   = ($urandom_range(4) == 0) ? $urandom_range(len) : -1;
      for (int i = 0; i <= len; i++) begin wd[i] = $urandom; ws[i] = 4'($urandom); end
      do_write(addr, len, size, burst, id, bad, $urandom_range(3));
      do_read(addr, len, size, burst, id, ($urandom_range(2) == 0) ? $urandom_range(len) : -1);
    end

    // Reset after the first of four beats: that beat lands, no response follows.
    wd[0] = 32'h5A5A5A5A; ws[0] = 4'hF;
    model[32'h40 >> 2] = 32'h5A5A5A5A;
    @(negedge CLK);
    awaddr = 32'h40; awlen = 8'd3; awsize = 3'd2; awburst = 2'd1; awid = 6'd9; awvalid = 1'b1;
    wait_for(0, "awready_mid");
    @(negedge CLK);
    awvalid = 1'b0;
    wdata = wd[0]; wstrb = 4'hF; wlast = 1'b0; wvalid = 1'b1;
    wait_for(1, "wready_mid");
    @(negedge CLK);
    wvalid = 1'b0;
    RST_N = 1'b0;
    #1;
    check_reset_outputs("reset_mid_outputs");
    @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
    chk("awready_after_mid_reset", 64'(awready), 64'd1);
    for (int k = 0; k < 5; k++) begin
      chk("no_bvalid_after_reset", 64'(bvalid), 64'd0);
      @(negedge CLK);
    end
    do_read(32'h40, 3, 2, 1, 6'd4, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
